// File: rtl/final_adder_seq.sv
// final_adder_seq: chunk-serial carry-propagate adder that turns the two
// carry-save rows of the approximate 6x6 multiplier into the final product.
// Optional feature macro: APPROX_BIAS_EN adds the BIAS compensation constant
// as a third operand and saturates the product on overflow.
module final_adder_seq #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned CHUNK = 4
`ifdef APPROX_BIAS_EN
  ,
  parameter logic [WIDTH-1:0] BIAS = WIDTH'(3)
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_row0,
  input  logic [WIDTH-1:0] in_row1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_prod,
  output logic             out_sat,
  output logic             busy
);

  localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned PADW   = NCHUNK * CHUNK;
  localparam int unsigned PW     = WIDTH + 1;
`ifdef APPROX_BIAS_EN
  localparam int unsigned CW     = 2;
  localparam logic [PADW-1:0] BIAS_PAD = PADW'(BIAS);
`else
  localparam int unsigned CW     = 1;
`endif
  localparam int unsigned SW     = CHUNK + CW;
  localparam int unsigned FW     = PADW + CW;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   carry_q, carry_d;
  logic [PADW-1:0] acc_q, acc_d;
  logic [PADW-1:0] row0_q, row0_d;
  logic [PADW-1:0] row1_q, row1_d;
  logic [PW-1:0]   prod_d;
  logic            sat_d;
  logic            in_ready_d;
  logic            out_valid_d;
  logic            busy_d;
  logic [SW-1:0]   chunk_sum;
  logic [FW-1:0]   full_sum;

  // State, datapath and registered outputs; rows are zero-padded to whole chunks
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      carry_q   <= '0;
      acc_q     <= '0;
      row0_q    <= '0;
      row1_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_sat   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      acc_q     <= acc_d;
      row0_q    <= row0_d;
      row1_q    <= row1_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_prod  <= prod_d;
      out_sat   <= sat_d;
      busy      <= busy_d;
    end
  end

  // Next state, one chunk addition per ADD cycle, and next registered outputs
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    row0_d   = row0_q;
    row1_d   = row1_q;
    prod_d   = out_prod;
    sat_d    = out_sat;
    full_sum = '0;

    chunk_sum = SW'(row0_q[idx_q*CHUNK +: CHUNK])
              + SW'(row1_q[idx_q*CHUNK +: CHUNK])
`ifdef APPROX_BIAS_EN
              + SW'(BIAS_PAD[idx_q*CHUNK +: CHUNK])
`endif
              + SW'(carry_q);

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          row0_d  = PADW'(in_row0);
          row1_d  = PADW'(in_row1);
          idx_d   = '0;
          carry_d = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = CW'(chunk_sum >> CHUNK);
        if (idx_q == IW'(NCHUNK - 1)) begin
          // Padding bits are zero, so {carry, acc} is the exact sum
          full_sum = {carry_d, acc_d};
`ifdef APPROX_BIAS_EN
          if (|full_sum[FW-1:PW]) begin
            prod_d = '1;
            sat_d  = 1'b1;
          end else begin
            prod_d = PW'(full_sum);
            sat_d  = 1'b0;
          end
`else
          prod_d = PW'(full_sum);
          sat_d  = 1'b0;
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_final_adder_seq.sv
// Directed bench for final_adder_seq with hand-computed expected products.
module tb_final_adder_seq;

  localparam int unsigned WIDTH = 11;
`ifdef APPROX_BIAS_EN
  localparam logic [11:0] B = 12'd3;
`else
  localparam logic [11:0] B = 12'd0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_row0;
  logic [WIDTH-1:0]  in_row1;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH:0]    out_prod;
  logic              out_sat;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] pa [4] = '{11'h001, 11'h400, 11'h3C3, 11'h7F0};
  logic [10:0] pb [4] = '{11'h001, 11'h400, 11'h0F0, 11'h00F};
  logic [11:0] pe [4] = '{12'h002, 12'h800, 12'h4B3, 12'h7FF};

  final_adder_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row0   (in_row0),
    .in_row1   (in_row1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_row0   = '0;
    in_row1   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 16'(in_ready), 16'h1);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_out_prod", 16'(out_prod), 16'h0);
    check("rst_out_sat", 16'(out_sat), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);

    // Basic transfer with exact cycle timing
    in_valid = 1'b1; in_row0 = 11'h155; in_row1 = 11'h2AA; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_c1_in_ready", 16'(in_ready), 16'h0);
    check("t1_c1_busy", 16'(busy), 16'h1);
    tick();
    check("t1_c2_in_ready", 16'(in_ready), 16'h0);
    tick();
    check("t1_c3_out_valid", 16'(out_valid), 16'h0);
    check("t1_c3_in_ready", 16'(in_ready), 16'h0);
    tick();
    check("t1_c4_out_valid", 16'(out_valid), 16'h1);
    check("t1_c4_out_prod", 16'(out_prod), 16'(12'h3FF + B));
    check("t1_c4_in_ready", 16'(in_ready), 16'h0);
    tick();
    check("t1_c5_in_ready", 16'(in_ready), 16'h1);
    check("t1_c5_out_valid", 16'(out_valid), 16'h0);
    check("t1_c5_busy", 16'(busy), 16'h0);
    check("t1_c5_prod_hold", 16'(out_prod), 16'(12'h3FF + B));

    // Full ripple through every chunk
    in_valid = 1'b1; in_row0 = 11'h7FF; in_row1 = 11'h7FF;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("t2_out_valid", 16'(out_valid), 16'h1);
`ifdef APPROX_BIAS_EN
    check("t2_out_prod", 16'(out_prod), 16'hFFF);
    check("t2_out_sat", 16'(out_sat), 16'h1);
`else
    check("t2_out_prod", 16'(out_prod), 16'hFFE);
    check("t2_out_sat", 16'(out_sat), 16'h0);
`endif
    tick();

    // Back-pressure: result held while the consumer stalls
    out_ready = 1'b0;
    in_valid = 1'b1; in_row0 = 11'h100; in_row1 = 11'h0FF;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_row0  = 11'h011 + 11'(i);
      in_row1  = 11'h022;
      check("t3_stall_out_valid", 16'(out_valid), 16'h1);
      check("t3_stall_out_prod", 16'(out_prod), 16'(12'h1FF + B));
      check("t3_stall_in_ready", 16'(in_ready), 16'h0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("t3_release_out_valid", 16'(out_valid), 16'h1);
    tick();
    check("t3_after_out_valid", 16'(out_valid), 16'h0);
    check("t3_after_in_ready", 16'(in_ready), 16'h1);
    tick();
    check("t3_single_out_valid", 16'(out_valid), 16'h0);
    check("t3_single_busy", 16'(busy), 16'h0);

    // Reset during the second ADD cycle
    in_valid = 1'b1; in_row0 = 11'h0AA; in_row1 = 11'h011;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_in_ready", 16'(in_ready), 16'h1);
    check("t4_rst_out_valid", 16'(out_valid), 16'h0);
    check("t4_rst_out_prod", 16'(out_prod), 16'h0);
    check("t4_rst_busy", 16'(busy), 16'h0);
    in_valid = 1'b1; in_row0 = 11'h123; in_row1 = 11'h321;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("t4_new_out_valid", 16'(out_valid), 16'h1);
    check("t4_new_out_prod", 16'(out_prod), 16'(12'h444 + B));
    tick();

    // Back-to-back stream with in_valid held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_row0 = pa[i];
      in_row1 = pb[i];
      check("t5_accept_in_ready", 16'(in_ready), 16'h1);
      tick();
      in_row0 = 11'h5A5;
      in_row1 = 11'h25A;
      check("t5_c1_out_valid", 16'(out_valid), 16'h0);
      tick(); tick();
      check("t5_c3_out_valid", 16'(out_valid), 16'h0);
      tick();
      check("t5_c4_out_valid", 16'(out_valid), 16'h1);
      check("t5_c4_out_prod", 16'(out_prod), 16'(pe[i] + B));
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("t5_end_out_valid", 16'(out_valid), 16'h0);

`ifdef APPROX_BIAS_EN
    // Bias compensation without saturation
    in_valid = 1'b1; in_row0 = 11'h0F0; in_row1 = 11'h00F;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("t6_out_prod", 16'(out_prod), 16'h102);
    check("t6_out_sat", 16'(out_sat), 16'h0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/final_adder_seq.md
Name: final_adder_seq

Overview:
- Carry-propagate final stage of the approximate 6x6 multiplier.
- Consumes the two carry-save rows produced by the reduction stage and adds them chunk-serially, CHUNK bits per cycle, giving the (WIDTH+1)-bit product.
- Sits between the reduction stage and the product consumer, with valid/ready handshakes on both sides.
- Trades latency for a short carry chain.

Parameters:
- WIDTH, 11: width of each input row; the product is WIDTH+1 bits.
- CHUNK, 4: bits added per cycle. NCHUNK = ceil(WIDTH/CHUNK), which is 3 at the defaults.
- BIAS, 3: error-compensation constant, WIDTH bits. Used only when APPROX_BIAS_EN is defined.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  the row pair is valid.
- in_ready  out  1  the block can accept a row pair.
- in_row0  in  WIDTH  carry-save row 0.
- in_row1  in  WIDTH  carry-save row 1.
- out_valid  out  1  out_prod and out_sat are valid.
- out_ready  in  1  the consumer takes the result.
- out_prod  out  WIDTH+1  sum of the rows.
- out_sat  out  1  the result was saturated.
- busy  out  1  high in ADD or DONE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_prod=0, out_sat=0, busy=0. Chunk index and carry are cleared.
- Reset asserted mid-operation discards the in-flight operands; the block is in IDLE on the next cycle.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch both rows, set index=0 and carry=0, go to ADD.
  - in_row0/in_row1 are ignored at all other times.
- ADD (in_ready=0, busy=1), one chunk per cycle at index k:
  - s = row0[kC +: C] + row1[kC +: C] + carry. Bits at or above WIDTH in the last chunk are treated as 0.
  - Write s[C-1:0] into result bits [kC +: C], truncated at WIDTH.
  - carry = s >> C.
  - At k = NCHUNK-1: result[WIDTH] = final carry, go to DONE. Otherwise k = k+1.
- DONE:
  - out_valid=1; out_prod and out_sat are stable until the handshake.
  - On out_ready, the next state is IDLE and out_valid drops.
  - in_ready stays 0 in DONE; there is no overlap between accept and deliver.
- Timing:
  - out_valid rises NCHUNK+1 cycles after the accept cycle (cycle 4 at the defaults).
  - With out_ready held high, throughput is one result per NCHUNK+2 cycles.
  - out_ready asserted while out_valid=0 has no effect.
- Arithmetic:
  - Without the macro, out_prod = (in_row0 + in_row1) mod 2^(WIDTH+1), which is exact because no overflow is possible.
  - The carry register is 1 bit without the macro and 2 bits with it.
- out_prod holds its last value in IDLE. It is zero only after reset.

Optional Feature:
- Macro: APPROX_BIAS_EN.
- Defined:
  - BIAS[kC +: C] is added as a third operand in each chunk, so the carry ranges 0..2.
  - If the final carry is 2, or the true sum is at least 2^(WIDTH+1), out_prod is forced to all ones and out_sat=1.
  - Otherwise out_prod = row0 + row1 + BIAS and out_sat=0.
- Undefined:
  - There is no bias operand, and the carry register is 1 bit.
  - out_sat is tied to 0.
- Latency and handshake are identical with and without the macro.

Test Plan:
- Reset, then in_row0=0x155, in_row1=0x2AA, out_ready=1 -> in_ready=0 for cycles 1-4; out_prod=0x3FF and out_valid=1 at cycle 4; back in IDLE at cycle 5.
- in_row0=0x7FF, in_row1=0x7FF (macro off) -> out_prod=0xFFE, out_sat=0, with carry rippling through all 3 chunks.
- Result pending, out_ready held low 5 cycles -> out_valid and out_prod stable; in_ready=0 throughout; in_valid pulses ignored; release -> a single transfer.
- rst asserted during the 2nd ADD cycle -> next cycle in IDLE with in_ready=1, out_valid=0, out_prod=0; a new operand pair completes correctly.
- in_valid held high with 4 distinct pairs, out_ready=1 -> 4 correct results spaced 5 cycles apart, in order, none dropped or duplicated.
- APPROX_BIAS_EN, BIAS=3:
  - in_row0=0x0F0, in_row1=0x00F -> out_prod=0x102, out_sat=0.
  - in_row0=0x7FF, in_row1=0x7FF -> out_prod=0xFFF, out_sat=1.
